// File: rtl/line_buf_pkg.sv
//------------------------------------------------------------------------------
// Module   : line_buf_pkg
// Brief    : Shared widths and frame-geometry defaults for the line buffer and
//            the downstream 3x3 window stage, so both stages agree.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package line_buf_pkg;

   // Default pixel width (RGB888)
   localparam int PIX_W_DEF      = 24;

   // Column / row counter widths (PIC_WIDTH <= 511, PIC_HEIGHT <= 1023)
   localparam int COL_W          = 9;
   localparam int ROW_W          = 10;

   // Default frame geometry
   localparam int PIC_WIDTH_DEF  = 320;
   localparam int PIC_HEIGHT_DEF = 240;

endpackage : line_buf_pkg

`default_nettype wire

// File: rtl/line_buffer_3row_ram.sv
//------------------------------------------------------------------------------
// Module   : line_ram
// Brief    : Simple dual-port, single-clock, read-first line RAM. The read
//            port is combinational, so a read at the address being written in
//            the same cycle returns the value stored before that write.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module line_ram #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 320,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [0:DEPTH-1];

   // Read returns the stored (pre-write) word
   assign rdata = mem[raddr];

   // Write port; contents need no reset, priming logic masks stale data
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

endmodule : line_ram

`default_nettype wire

// File: rtl/line_buffer_3row.sv
//------------------------------------------------------------------------------
// Module   : line_buffer_3row
// Brief    : Streaming 3-row line buffer feeding a 3x3 window stage. Keeps the
//            two previous rows in line RAMs and emits a vertically aligned
//            column (top = row y-2, mid = row y-1, bottom = row y) one cycle
//            after every valid input pixel.
//            Optional feature macro: LINEBUF_EDGE_REPLICATE_EN
//              defined   - rows 0 and 1 are output with the top border
//                          replicated (output height = PIC_HEIGHT)
//              undefined - rows 0 and 1 only prime the RAMs
//                          (output height = PIC_HEIGHT-2)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module line_buffer_3row
   import line_buf_pkg::*;
#(
   parameter int WIDTH      = PIX_W_DEF,
   parameter int PIC_WIDTH  = PIC_WIDTH_DEF,
   parameter int PIC_HEIGHT = PIC_HEIGHT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sof,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] din,
   output logic             valid_out,
   output logic [WIDTH-1:0] dout1,
   output logic [WIDTH-1:0] dout2,
   output logic [WIDTH-1:0] dout3,
   output logic [ROW_W-1:0] row_idx,
   output logic [COL_W-1:0] col_idx
);

   localparam int              RAM_AW   = $clog2(PIC_WIDTH);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(PIC_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(PIC_HEIGHT - 1);

   logic [COL_W-1:0] col_cnt_q, col_cnt_d, col_eff;
   logic [ROW_W-1:0] row_cnt_q, row_cnt_d, row_eff;
   logic             valid_out_q, valid_out_d;
   logic [WIDTH-1:0] dout1_q, dout1_d;
   logic [WIDTH-1:0] dout2_q, dout2_d;
   logic [WIDTH-1:0] dout3_q, dout3_d;
   logic [ROW_W-1:0] row_idx_q, row_idx_d;
   logic [COL_W-1:0] col_idx_q, col_idx_d;
   logic [WIDTH-1:0] ram_a_rd;
   logic [WIDTH-1:0] ram_b_rd;

   // Position of the current pixel: sof forces (0,0) whatever the counters say
   always_comb begin
      col_eff = col_cnt_q;
      row_eff = row_cnt_q;
      if (valid_in && sof) begin
         col_eff = '0;
         row_eff = '0;
      end
   end

   // ram_a holds row y-1; the word it gives up each pixel moves into ram_b
   line_ram #(
      .WIDTH (WIDTH),
      .DEPTH (PIC_WIDTH),
      .AW    (RAM_AW)
   ) u_ram_a (
      .clk   (clk),
      .we    (valid_in),
      .waddr (col_eff[RAM_AW-1:0]),
      .wdata (din),
      .raddr (col_eff[RAM_AW-1:0]),
      .rdata (ram_a_rd)
   );

   // ram_b holds row y-2
   line_ram #(
      .WIDTH (WIDTH),
      .DEPTH (PIC_WIDTH),
      .AW    (RAM_AW)
   ) u_ram_b (
      .clk   (clk),
      .we    (valid_in),
      .waddr (col_eff[RAM_AW-1:0]),
      .wdata (ram_a_rd),
      .raddr (col_eff[RAM_AW-1:0]),
      .rdata (ram_b_rd)
   );

   // Next-state: advance counters and capture the column on each valid pixel
   always_comb begin
      col_cnt_d   = col_cnt_q;
      row_cnt_d   = row_cnt_q;
      valid_out_d = 1'b0;
      dout1_d     = dout1_q;
      dout2_d     = dout2_q;
      dout3_d     = dout3_q;
      row_idx_d   = row_idx_q;
      col_idx_d   = col_idx_q;

      if (valid_in) begin
         if (col_eff == COL_LAST) begin
            col_cnt_d = '0;
            row_cnt_d = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
         end else begin
            col_cnt_d = col_eff + 1'b1;
            row_cnt_d = row_eff;
         end

         dout3_d   = din;
         row_idx_d = row_eff;
         col_idx_d = col_eff;

`ifdef LINEBUF_EDGE_REPLICATE_EN
         // Every row is emitted; missing rows above the frame are replicated
         valid_out_d = 1'b1;
         if (row_eff == '0) begin
            dout2_d = din;
            dout1_d = din;
         end else if (row_eff == ROW_W'(1)) begin
            dout2_d = ram_a_rd;
            dout1_d = ram_a_rd;
         end else begin
            dout2_d = ram_a_rd;
            dout1_d = ram_b_rd;
         end
`else
         // Rows 0 and 1 only prime the RAMs
         valid_out_d = (row_eff >= ROW_W'(2));
         dout2_d     = ram_a_rd;
         dout1_d     = ram_b_rd;
`endif
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt_q   <= '0;
         row_cnt_q   <= '0;
         valid_out_q <= 1'b0;
         dout1_q     <= '0;
         dout2_q     <= '0;
         dout3_q     <= '0;
         row_idx_q   <= '0;
         col_idx_q   <= '0;
      end else begin
         col_cnt_q   <= col_cnt_d;
         row_cnt_q   <= row_cnt_d;
         valid_out_q <= valid_out_d;
         dout1_q     <= dout1_d;
         dout2_q     <= dout2_d;
         dout3_q     <= dout3_d;
         row_idx_q   <= row_idx_d;
         col_idx_q   <= col_idx_d;
      end
   end

   assign valid_out = valid_out_q;
   assign dout1     = dout1_q;
   assign dout2     = dout2_q;
   assign dout3     = dout3_q;
   assign row_idx   = row_idx_q;
   assign col_idx   = col_idx_q;

endmodule : line_buffer_3row

`default_nettype wire

// File: tb/tb_line_buffer_3row.sv
//------------------------------------------------------------------------------
// Module   : tb_line_buffer_3row
// Brief    : Directed self-checking bench for line_buffer_3row on a 4x4 frame.
//            Pixel value of frame f, row r, column c is f*128 + r*16 + c.
//            Honours LINEBUF_EDGE_REPLICATE_EN when defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_line_buffer_3row;

   localparam int W  = 24;
   localparam int PW = 4;
   localparam int PH = 4;
`ifdef LINEBUF_EDGE_REPLICATE_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif
   localparam int EXP_COLS = EDGE ? PW * PH : PW * (PH - 2);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sof = 1'b0;
   logic          valid_in = 1'b0;
   logic [W-1:0]  din = '0;
   logic          valid_out;
   logic [W-1:0]  dout1, dout2, dout3;
   logic [9:0]    row_idx;
   logic [8:0]    col_idx;
   logic [91:0]   act;

   int vectors = 0;
   int fails   = 0;

   line_buffer_3row #(
      .WIDTH      (W),
      .PIC_WIDTH  (PW),
      .PIC_HEIGHT (PH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sof       (sof),
      .valid_in  (valid_in),
      .din       (din),
      .valid_out (valid_out),
      .dout1     (dout1),
      .dout2     (dout2),
      .dout3     (dout3),
      .row_idx   (row_idx),
      .col_idx   (col_idx)
   );

   always #5 clk = ~clk;

   // Observed column: {valid, top, mid, bottom, row, col}
   assign act = {valid_out, dout1, dout2, dout3, row_idx, col_idx};

   function automatic logic [W-1:0] pix(int f, int r, int c);
      return W'(f * 128 + r * 16 + c);
   endfunction

   // Expected output word after pixel (r,c) of frame f; v=0 for the idle-hold case
   function automatic logic [91:0] exp_vec(int f, int r, int c, bit v);
      logic [W-1:0] d1, d2, d3;
      logic         vo;
      d3 = pix(f, r, c);
      if (r >= 2) begin
         d2 = pix(f, r - 1, c);
         d1 = pix(f, r - 2, c);
      end else if (r == 1) begin
         d2 = pix(f, 0, c);
         d1 = EDGE ? pix(f, 0, c) : '0;
      end else begin
         d2 = EDGE ? d3 : '0;
         d1 = EDGE ? d3 : '0;
      end
      vo = v && (EDGE || r >= 2);
      return {vo, d1, d2, d3, 10'(r), 9'(c)};
   endfunction

   // Fields with defined values: without edge replication, stale RAM data on
   // the priming rows is unspecified
   function automatic logic [91:0] mask(int r);
      logic [91:0] m;
      m = '1;
      if (!EDGE && r < 2)  m[90:67] = '0;
      if (!EDGE && r == 0) m[66:43] = '0;
      return m;
   endfunction

   // Drive one cycle of input, return 1 time unit after the clock edge
   task automatic apply(input logic v, input logic s, input logic [W-1:0] d);
      valid_in = v;
      sof      = s;
      din      = d;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      sof      = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      vectors++;
      if (act !== 92'd0) begin
         fails++;
         $display("FAIL reset_state: got %h want %h", act, 92'd0);
      end
      rst_n = 1'b1;
      apply(1'b0, 1'b0, '0);
      apply(1'b0, 1'b0, '0);
      vectors++;
      if (act !== 92'd0) begin
         fails++;
         $display("FAIL reset_idle: got %h want %h", act, 92'd0);
      end
   endtask

   task automatic test_continuous();
      logic [91:0] e, m;
      int nvalid;
      nvalid = 0;
      for (int r = 0; r < PH; r++) begin
         for (int c = 0; c < PW; c++) begin
            apply(1'b1, (r == 0 && c == 0), pix(0, r, c));
            e = exp_vec(0, r, c, 1'b1);
            m = mask(r);
            vectors++;
            if ((act & m) !== (e & m)) begin
               fails++;
               $display("FAIL continuous r%0d c%0d: got %h want %h", r, c, act & m, e & m);
            end
            if (valid_out === 1'b1) nvalid++;
         end
      end
      apply(1'b0, 1'b0, '0);
      vectors++;
      if (nvalid != EXP_COLS) begin
         fails++;
         $display("FAIL continuous_count: got %0d want %0d", nvalid, EXP_COLS);
      end
   endtask

   task automatic test_gaps();
      logic [91:0] e, m;
      int lr, lc, idles;
      lr = PH - 1;
      lc = PW - 1;
      for (int r = 0; r < PH; r++) begin
         for (int c = 0; c < PW; c++) begin
            idles = (c == 1) ? 1 : 0;
            if ($urandom_range(0, 99) < 30) idles++;
            for (int k = 0; k < idles; k++) begin
               apply(1'b0, 1'b0, '0);
               e = exp_vec(0, lr, lc, 1'b0);
               m = mask(lr);
               vectors++;
               if ((act & m) !== (e & m)) begin
                  fails++;
                  $display("FAIL gap_hold r%0d c%0d: got %h want %h", lr, lc, act & m, e & m);
               end
            end
            apply(1'b1, (r == 0 && c == 0), pix(0, r, c));
            e = exp_vec(0, r, c, 1'b1);
            m = mask(r);
            vectors++;
            if ((act & m) !== (e & m)) begin
               fails++;
               $display("FAIL gap_pixel r%0d c%0d: got %h want %h", r, c, act & m, e & m);
            end
            lr = r;
            lc = c;
         end
      end
   endtask

   // Stream a complete frame f with full checking; sof on its first pixel optional
   task automatic test_frame(input int f, input bit with_sof, input string tag);
      logic [91:0] e, m;
      for (int r = 0; r < PH; r++) begin
         for (int c = 0; c < PW; c++) begin
            apply(1'b1, with_sof && r == 0 && c == 0, pix(f, r, c));
            e = exp_vec(f, r, c, 1'b1);
            m = mask(r);
            vectors++;
            if ((act & m) !== (e & m)) begin
               fails++;
               $display("FAIL %s f%0d r%0d c%0d: got %h want %h", tag, f, r, c, act & m, e & m);
            end
         end
      end
   endtask

   task automatic test_sof_mid();
      logic [91:0] e, m;
      // Six pixels of frame 8, then frame 9 restarts with sof at pixel 6
      for (int p = 0; p < 6; p++) begin
         apply(1'b1, p == 0, pix(8, p / PW, p % PW));
         e = exp_vec(8, p / PW, p % PW, 1'b1);
         m = mask(p / PW);
         vectors++;
         if ((act & m) !== (e & m)) begin
            fails++;
            $display("FAIL sof_pre p%0d: got %h want %h", p, act & m, e & m);
         end
      end
      test_frame(9, 1'b1, "sof_mid");
   endtask

   task automatic test_reset_mid();
      logic [91:0] e, m;
      for (int p = 0; p < 2 * PW + 2; p++) begin
         apply(1'b1, p == 0, pix(4, p / PW, p % PW));
         e = exp_vec(4, p / PW, p % PW, 1'b1);
         m = mask(p / PW);
         vectors++;
         if ((act & m) !== (e & m)) begin
            fails++;
            $display("FAIL rst_pre p%0d: got %h want %h", p, act & m, e & m);
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (act !== 92'd0) begin
         fails++;
         $display("FAIL rst_async: got %h want %h", act, 92'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply(1'b0, 1'b0, '0);
      vectors++;
      if (act !== 92'd0) begin
         fails++;
         $display("FAIL rst_release: got %h want %h", act, 92'd0);
      end
      test_frame(5, 1'b1, "rst_restart");
   endtask

   task automatic test_back_to_back();
      test_frame(6, 1'b1, "b2b_first");
      test_frame(7, 1'b0, "b2b_second");
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_gaps();
      test_sof_mid();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule : tb_line_buffer_3row

`default_nettype wire
